// File: rtl/writeback_pkg.sv
// Shared types and sizing for the writeback stage.
//   wb_entry_t  : one buffered result (scalar or full vector destination)
//   asm_state_t : vector-load assembler states
//   *_MASK_W    : widths of the per-register pending-write masks
package writeback_pkg;

  localparam int unsigned DATA_WIDTH    = 19;
  localparam int unsigned WIDTH         = 8;
  localparam int unsigned VECTOR_SIZE   = 8;
  localparam int unsigned ADDRESS_WIDTH = 4;
  localparam int unsigned SCALAR_REGNUM = 16;
  localparam int unsigned VECTOR_REGNUM = 16;

  localparam int unsigned VEC_DATA_W    = VECTOR_SIZE * WIDTH;
  localparam int unsigned LANE_IDX_W    = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
  localparam int unsigned SCALAR_MASK_W = SCALAR_REGNUM;
  localparam int unsigned VECTOR_MASK_W = VECTOR_REGNUM;

  typedef struct packed {
    logic                     isVector;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    scalarData;
    logic [VEC_DATA_W-1:0]    vectorData;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PENDING = 2'd2
  } asm_state_t;

  // One-hot decode of a register address into a scalar pending mask
  function automatic logic [SCALAR_MASK_W-1:0] scalar_onehot(input logic [ADDRESS_WIDTH-1:0] addr);
    logic [SCALAR_MASK_W-1:0] m;
    m       = '0;
    m[addr] = 1'b1;
    return m;
  endfunction

  // One-hot decode of a register address into a vector pending mask
  function automatic logic [VECTOR_MASK_W-1:0] vector_onehot(input logic [ADDRESS_WIDTH-1:0] addr);
    logic [VECTOR_MASK_W-1:0] m;
    m       = '0;
    m[addr] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/writeback_fifo.sv
// Result buffer: circular FIFO of wb_entry_t.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   push_i/push_data_i : write one entry (ignored when full)
//   pop_i           : retire the head entry (ignored when empty)
//   head_c          : current head entry
//   full_c, empty_c : occupancy flags decoded from the count register
//   count_o         : number of stored entries
//   entries_o       : raw storage, with valid_c marking live slots
module writeback_fifo
  import writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push_i,
  input  wb_entry_t                         push_data_i,
  input  logic                              pop_i,
  output wb_entry_t                         head_c,
  output logic                              full_c,
  output logic                              empty_c,
  output logic [$clog2(DEPTH):0]            count_o,
  output wb_entry_t [DEPTH-1:0]             entries_o,
  output logic [DEPTH-1:0]                  valid_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  do_push;
  logic                  do_pop;

  assign full_c    = (count_q == CNT_W'(DEPTH));
  assign empty_c   = (count_q == '0);
  assign do_push   = push_i && !full_c;
  assign do_pop    = pop_i && !empty_c;
  assign head_c    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign entries_o = mem_q;

  // A slot is live when its distance from the read pointer is below the count
  always_comb begin
    valid_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_c[i] = (CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr_q)) < count_q);
    end
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: buffers execute results, assembles serialized vector
// loads and drives the single shared register-file write port.
// Ports:
//   clock, reset           : clock, async active-low reset
//   res*                   : execute result handshake and payload
//   ld*                    : vector-load lane stream
//   writeEnable*/write*    : registered register-file write port
//   scalarPending/vectorPending : per-register pending-write masks
//   busy                   : any buffered, assembling or issuing work
// Optional feature: define WRITEBACK_HAZARD_EN to build pending-write
// tracking; otherwise both masks are tied to 0.
module writeback_unit
  import writeback_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     resValid,
  output logic                     resReady,
  input  logic                     resIsVector,
  input  logic [ADDRESS_WIDTH-1:0] resAddress,
  input  logic [DATA_WIDTH-1:0]    resScalarData,
  input  logic [VEC_DATA_W-1:0]    resVectorData,
  input  logic                     ldValid,
  output logic                     ldReady,
  input  logic                     ldFirst,
  input  logic [ADDRESS_WIDTH-1:0] ldAddress,
  input  logic [WIDTH-1:0]         ldLane,
  output logic                     writeEnableScalar,
  output logic                     writeEnableVector,
  output logic [ADDRESS_WIDTH-1:0] writeAddress,
  output logic [DATA_WIDTH-1:0]    writeScalarData,
  output logic [VEC_DATA_W-1:0]    writeVectorData,
  output logic [SCALAR_MASK_W-1:0] scalarPending,
  output logic [VECTOR_MASK_W-1:0] vectorPending,
  output logic                     busy
);

  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Result buffer
  wb_entry_t                  res_entry_c;
  wb_entry_t                  fifo_head_c;
  wb_entry_t [FIFO_DEPTH-1:0] fifo_entries;
  logic [FIFO_DEPTH-1:0]      fifo_valid_c;
  logic [FIFO_CNT_W-1:0]      fifo_count;
  logic                       fifo_full_c;
  logic                       fifo_empty_c;
  logic                       fifo_pop_c;
  logic                       res_push_c;

  // Assembler
  asm_state_t                 state_q, state_d;
  logic [VEC_DATA_W-1:0]      lanes_q, lanes_d;
  logic [ADDRESS_WIDTH-1:0]   asm_addr_q, asm_addr_d;
  logic [LANE_IDX_W-1:0]      lane_idx_q, lane_idx_d;
  logic                       ld_ready_c;
  logic                       asm_pending_c;
  logic                       asm_grant_c;
  logic                       ld_fire_c;
  logic                       last_lane_c;

  // Write port
  logic                       wr_s_q, wr_s_d;
  logic                       wr_v_q, wr_v_d;
  logic [ADDRESS_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]      wr_sdata_q, wr_sdata_d;
  logic [VEC_DATA_W-1:0]      wr_vdata_q, wr_vdata_d;

  // Occupancy and raw entries are only consumed by hazard tracking
  logic                       unused_fifo_c;
  assign unused_fifo_c = ^{fifo_entries, fifo_valid_c, fifo_count};

  // ---------------------------------------------------------------- FIFO
  always_comb begin
    res_entry_c            = '0;
    res_entry_c.isVector   = resIsVector;
    res_entry_c.address    = resAddress;
    res_entry_c.scalarData = resScalarData;
    res_entry_c.vectorData = resVectorData;
  end

  // Ready depends on the stored count only, never on a same-cycle pop
  assign resReady   = !fifo_full_c;
  assign res_push_c = resValid && !fifo_full_c;

  writeback_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clock),
    .rst_n       (reset),
    .push_i      (res_push_c),
    .push_data_i (res_entry_c),
    .pop_i       (fifo_pop_c),
    .head_c      (fifo_head_c),
    .full_c      (fifo_full_c),
    .empty_c     (fifo_empty_c),
    .count_o     (fifo_count),
    .entries_o   (fifo_entries),
    .valid_c     (fifo_valid_c)
  );

  // ----------------------------------------------------------- assembler
  assign ld_fire_c   = ldValid && ld_ready_c;
  assign last_lane_c = (lane_idx_q == LANE_IDX_W'(VECTOR_SIZE - 1));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; an ldFirst beat in COLLECT restarts but stays in COLLECT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ld_fire_c && ldFirst) state_d = COLLECT;
      COLLECT: if (ld_fire_c && !ldFirst && last_lane_c) state_d = PENDING;
      PENDING: if (asm_grant_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ld_ready_c    = 1'b1;
    asm_pending_c = 1'b0;
    if (state_q == PENDING) begin
      ld_ready_c    = 1'b0;
      asm_pending_c = 1'b1;
    end
  end

  assign ldReady = ld_ready_c;

  // Lane buffer, destination and index; the index holds at the last lane
  // while PENDING and only returns to 0 when the vector is written
  always_comb begin
    lanes_d    = lanes_q;
    asm_addr_d = asm_addr_q;
    lane_idx_d = lane_idx_q;
    if (ld_fire_c) begin
      if (ldFirst) begin
        lanes_d[WIDTH-1:0] = ldLane;
        asm_addr_d         = ldAddress;
        lane_idx_d         = LANE_IDX_W'(1);
      end else if (state_q == COLLECT) begin
        for (int unsigned i = 0; i < VECTOR_SIZE; i++) begin
          if (lane_idx_q == LANE_IDX_W'(i)) begin
            lanes_d[i*WIDTH +: WIDTH] = ldLane;
          end
        end
        if (!last_lane_c) begin
          lane_idx_d = lane_idx_q + LANE_IDX_W'(1);
        end
      end
    end else if (asm_grant_c) begin
      lane_idx_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lanes_q    <= '0;
      asm_addr_q <= '0;
      lane_idx_q <= '0;
    end else begin
      lanes_q    <= lanes_d;
      asm_addr_q <= asm_addr_d;
      lane_idx_q <= lane_idx_d;
    end
  end

  // ---------------------------------------------------------- arbitration
  // A completed vector load outranks the FIFO head
  assign asm_grant_c = asm_pending_c;
  assign fifo_pop_c  = !asm_pending_c && !fifo_empty_c;

  // ----------------------------------------------------------- write port
  always_comb begin
    wr_s_d     = 1'b0;
    wr_v_d     = 1'b0;
    wr_addr_d  = '0;
    wr_sdata_d = '0;
    wr_vdata_d = '0;
    if (asm_grant_c) begin
      wr_v_d     = 1'b1;
      wr_addr_d  = asm_addr_q;
      wr_vdata_d = lanes_q;
    end else if (fifo_pop_c) begin
      wr_addr_d = fifo_head_c.address;
      if (fifo_head_c.isVector) begin
        wr_v_d     = 1'b1;
        wr_vdata_d = fifo_head_c.vectorData;
      end else begin
        wr_s_d     = 1'b1;
        wr_sdata_d = fifo_head_c.scalarData;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_s_q     <= 1'b0;
      wr_v_q     <= 1'b0;
      wr_addr_q  <= '0;
      wr_sdata_q <= '0;
      wr_vdata_q <= '0;
    end else begin
      wr_s_q     <= wr_s_d;
      wr_v_q     <= wr_v_d;
      wr_addr_q  <= wr_addr_d;
      wr_sdata_q <= wr_sdata_d;
      wr_vdata_q <= wr_vdata_d;
    end
  end

  assign writeEnableScalar = wr_s_q;
  assign writeEnableVector = wr_v_q;
  assign writeAddress      = wr_addr_q;
  assign writeScalarData   = wr_sdata_q;
  assign writeVectorData   = wr_vdata_q;

  assign busy = !fifo_empty_c || (state_q != IDLE) || wr_s_q || wr_v_q;

  // -------------------------------------------------------- hazard masks
`ifdef WRITEBACK_HAZARD_EN
  logic [SCALAR_MASK_W-1:0] scalar_mask_c;
  logic [VECTOR_MASK_W-1:0] vector_mask_c;

  // Pending = buffered in the FIFO, being assembled, or strobing this cycle
  always_comb begin
    scalar_mask_c = '0;
    vector_mask_c = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_valid_c[i]) begin
        if (fifo_entries[i].isVector) begin
          vector_mask_c = vector_mask_c | vector_onehot(fifo_entries[i].address);
        end else begin
          scalar_mask_c = scalar_mask_c | scalar_onehot(fifo_entries[i].address);
        end
      end
    end
    if (wr_s_q) begin
      scalar_mask_c = scalar_mask_c | scalar_onehot(wr_addr_q);
    end
    if (wr_v_q) begin
      vector_mask_c = vector_mask_c | vector_onehot(wr_addr_q);
    end
    if (state_q != IDLE) begin
      vector_mask_c = vector_mask_c | vector_onehot(asm_addr_q);
    end
  end

  assign scalarPending = scalar_mask_c;
  assign vectorPending = vector_mask_c;
`else
  assign scalarPending = '0;
  assign vectorPending = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
`timescale 1ns/1ps
module tb_writeback_unit;
  import writeback_pkg::*;

  localparam int unsigned CW = 96;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     resValid;
  logic                     resReady;
  logic                     resIsVector;
  logic [ADDRESS_WIDTH-1:0] resAddress;
  logic [DATA_WIDTH-1:0]    resScalarData;
  logic [VEC_DATA_W-1:0]    resVectorData;
  logic                     ldValid;
  logic                     ldReady;
  logic                     ldFirst;
  logic [ADDRESS_WIDTH-1:0] ldAddress;
  logic [WIDTH-1:0]         ldLane;
  logic                     writeEnableScalar;
  logic                     writeEnableVector;
  logic [ADDRESS_WIDTH-1:0] writeAddress;
  logic [DATA_WIDTH-1:0]    writeScalarData;
  logic [VEC_DATA_W-1:0]    writeVectorData;
  logic [SCALAR_MASK_W-1:0] scalarPending;
  logic [VECTOR_MASK_W-1:0] vectorPending;
  logic                     busy;

  always #5 clock = ~clock;

  writeback_unit #(
    .FIFO_DEPTH (2)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .resValid          (resValid),
    .resReady          (resReady),
    .resIsVector       (resIsVector),
    .resAddress        (resAddress),
    .resScalarData     (resScalarData),
    .resVectorData     (resVectorData),
    .ldValid           (ldValid),
    .ldReady           (ldReady),
    .ldFirst           (ldFirst),
    .ldAddress         (ldAddress),
    .ldLane            (ldLane),
    .writeEnableScalar (writeEnableScalar),
    .writeEnableVector (writeEnableVector),
    .writeAddress      (writeAddress),
    .writeScalarData   (writeScalarData),
    .writeVectorData   (writeVectorData),
    .scalarPending     (scalarPending),
    .vectorPending     (vectorPending),
    .busy              (busy)
  );

  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  logic [CW-1:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  function automatic logic [CW-1:0] wr_rec(input logic en_s, input logic en_v,
                                           input logic [ADDRESS_WIDTH-1:0] a,
                                           input logic [DATA_WIDTH-1:0] sd,
                                           input logic [VEC_DATA_W-1:0] vd);
    return CW'({en_s, en_v, a, sd, vd});
  endfunction

  function automatic logic [CW-1:0] port_now();
    return wr_rec(writeEnableScalar, writeEnableVector, writeAddress, writeScalarData, writeVectorData);
  endfunction

  // Scoreboard: every strobe must match the oldest outstanding expectation
  always @(negedge clock) begin : mon
    if (reset === 1'b1 && (writeEnableScalar || writeEnableVector)) begin
      if (exp_q.size() == 0) check_eq("unexpected_write", port_now(), '0);
      else                   check_eq("write", port_now(), exp_q.pop_front());
    end
  end

  // Drive one result; expectation is queued at the cycle it is accepted
  task automatic res_beat(input logic isv, input logic [ADDRESS_WIDTH-1:0] a,
                          input logic [DATA_WIDTH-1:0] sd, input logic [VEC_DATA_W-1:0] vd,
                          output int waits);
    resValid      = 1'b1;
    resIsVector   = isv;
    resAddress    = a;
    resScalarData = sd;
    resVectorData = vd;
    waits = 0;
    forever begin
      @(negedge clock);
      if (resReady) break;
      waits++;
      if (waits > 30) break;
      @(posedge clock); #1;
    end
    if (resReady) exp_q.push_back(isv ? wr_rec(1'b0, 1'b1, a, '0, vd) : wr_rec(1'b1, 1'b0, a, sd, '0));
    else          check_eq("res_timeout", CW'(resReady), CW'(1));
    @(posedge clock); #1;
    resValid = 1'b0;
  endtask

  task automatic ld_beat(input logic first, input logic [ADDRESS_WIDTH-1:0] a,
                         input logic [WIDTH-1:0] lane, output int waits);
    ldValid   = 1'b1;
    ldFirst   = first;
    ldAddress = a;
    ldLane    = lane;
    waits = 0;
    forever begin
      @(negedge clock);
      if (ldReady) break;
      waits++;
      if (waits > 30) break;
      @(posedge clock); #1;
    end
    if (!ldReady) check_eq("ld_timeout", CW'(ldReady), CW'(1));
    @(posedge clock); #1;
    ldValid = 1'b0;
    ldFirst = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clock);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int                    w;
    int                    wsum;
    logic [VEC_DATA_W-1:0] vd;
    logic [VEC_DATA_W-1:0] rvd;
    logic                  risv;
    logic [ADDRESS_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rsd;

    reset = 1'b0;
    resValid = 1'b0; resIsVector = 1'b0; resAddress = '0; resScalarData = '0; resVectorData = '0;
    ldValid = 1'b0; ldFirst = 1'b0; ldAddress = '0; ldLane = '0;

    // Reset values
    #12;
    check_eq("rst_write_port", port_now(), '0);
    check_eq("rst_ready", CW'({ldReady, resReady}), CW'(2'b11));
    check_eq("rst_busy", CW'(busy), '0);
    check_eq("rst_masks", CW'({scalarPending, vectorPending}), '0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;

    // Single scalar result: latency and one-cycle strobe
    res_beat(1'b0, 4'd3, 19'h5A5A5, '0, w);
    @(negedge clock);
    check_eq("lat_before_strobe", CW'({writeEnableScalar, writeEnableVector}), '0);
`ifdef WRITEBACK_HAZARD_EN
    check_eq("mask_fifo_s3", CW'({scalarPending, vectorPending}), CW'({16'h0008, 16'h0000}));
`else
    check_eq("mask_off", CW'({scalarPending, vectorPending}), '0);
`endif
    @(negedge clock);
    check_eq("lat_strobe", CW'({writeEnableScalar, writeEnableVector}), CW'(2'b10));
    @(negedge clock);
    check_eq("strobe_single", CW'({writeEnableScalar, writeEnableVector}), '0);
    check_eq("busy_after_write", CW'(busy), '0);
    @(posedge clock); #1;

    // Three back-to-back results: one write per cycle, never back-pressured
    wsum = 0;
    res_beat(1'b0, 4'd1, 19'h00011, '0, w); wsum += w;
    res_beat(1'b1, 4'd2, 19'h7FFFF, 64'h0123_4567_89AB_CDEF, w); wsum += w;
    res_beat(1'b0, 4'd15, 19'h7FFFF, '0, w); wsum += w;
    check_eq("b2b_nostall", CW'(wsum), '0);
    idle_cycles(4);

    // Vector load to v7, lanes 0x10..0x17
    wsum = 0;
    vd = '0;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      vd[i*WIDTH +: WIDTH] = WIDTH'(8'h10 + i);
      ld_beat(i == 0, 4'd7, WIDTH'(8'h10 + i), w); wsum += w;
    end
    exp_q.push_back(wr_rec(1'b0, 1'b1, 4'd7, '0, vd));
    check_eq("ld_no_stall", CW'(wsum), '0);
    @(negedge clock);
    check_eq("ld_pending_ready", CW'({ldReady, busy}), CW'(2'b01));
    @(negedge clock);
    check_eq("ld_written_ready", CW'({ldReady, writeEnableVector}), CW'(2'b11));
    @(posedge clock); #1;
    idle_cycles(2);

    // Restart: 3 lanes to v5 abandoned by ldFirst for v2
    for (int i = 0; i < 3; i++) ld_beat(i == 0, 4'd5, WIDTH'(8'hA0 + i), w);
    vd = '0;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      vd[i*WIDTH +: WIDTH] = WIDTH'(8'h20 + i);
      ld_beat(i == 0, 4'd2, WIDTH'(8'h20 + i), w);
    end
    exp_q.push_back(wr_rec(1'b0, 1'b1, 4'd2, '0, vd));
    idle_cycles(4);

    // Pending load vs FIFO head: load first, FIFO fills during the stall
    vd = '0;
    for (int i = 0; i < VECTOR_SIZE - 1; i++) begin
      vd[i*WIDTH +: WIDTH] = WIDTH'(8'h30 + i);
      ld_beat(i == 0, 4'd11, WIDTH'(8'h30 + i), w);
    end
    vd[(VECTOR_SIZE-1)*WIDTH +: WIDTH] = 8'h37;
    ldValid = 1'b1; ldFirst = 1'b0; ldLane = 8'h37;
    resValid = 1'b1; resIsVector = 1'b0; resAddress = 4'd4; resScalarData = 19'h7FFFF; resVectorData = '0;
    @(negedge clock);
    check_eq("tie_both_ready", CW'({ldReady, resReady}), CW'(2'b11));
    exp_q.push_back(wr_rec(1'b0, 1'b1, 4'd11, '0, vd));
    exp_q.push_back(wr_rec(1'b1, 1'b0, 4'd4, 19'h7FFFF, '0));
    @(posedge clock); #1;
    ldValid = 1'b0;
    resAddress = 4'd5; resScalarData = 19'h00001;
    @(negedge clock);
    check_eq("tie_pending_room", CW'({ldReady, resReady}), CW'(2'b01));
    exp_q.push_back(wr_rec(1'b1, 1'b0, 4'd5, 19'h00001, '0));
    @(posedge clock); #1;
    resValid = 1'b0;
    @(negedge clock);
    check_eq("tie_full_load_first", CW'({resReady, writeEnableVector}), CW'(2'b01));
    @(posedge clock); #1;
    res_beat(1'b1, 4'd6, 19'h12345, 64'hDEAD_BEEF_0BAD_F00D, w);
    check_eq("tie_refill", CW'(w), '0);
    idle_cycles(5);

    // Randomised result stream
    wsum = 0;
    for (int k = 0; k < 6; k++) begin
      risv  = 1'($urandom_range(0, 1));
      raddr = ADDRESS_WIDTH'($urandom_range(0, 15));
      rsd   = DATA_WIDTH'($urandom);
      rvd   = {32'($urandom), 32'($urandom)};
      res_beat(risv, raddr, rsd, rvd, w); wsum += w;
    end
    check_eq("rand_nostall", CW'(wsum), '0);
    idle_cycles(5);

    // Reset during COLLECT with a buffered result: everything discarded
    for (int i = 0; i < 3; i++) ld_beat(i == 0, 4'd9, WIDTH'(8'h90 + i), w);
    res_beat(1'b0, 4'd8, 19'h0ABCD, '0, w);
`ifdef WRITEBACK_HAZARD_EN
    check_eq("mask_before_rst", CW'({scalarPending, vectorPending}), CW'({16'h0100, 16'h0200}));
`else
    check_eq("mask_off_busy", CW'({scalarPending, vectorPending}), '0);
`endif
    reset = 1'b0;
    exp_q.delete();
    #1;
    check_eq("midrst_write_port", port_now(), '0);
    check_eq("midrst_ready_busy", CW'({ldReady, resReady, busy}), CW'(3'b110));
    check_eq("midrst_masks", CW'({scalarPending, vectorPending}), '0);
    idle_cycles(2);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    // Lanes without ldFirst in IDLE are dropped
    for (int i = 0; i < VECTOR_SIZE; i++) ld_beat(1'b0, 4'd9, WIDTH'(8'h90 + i), w);
    idle_cycles(6);
    check_eq("post_rst_idle", CW'(busy), '0);

    // Drain any outstanding expectations within a bounded time
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clock);
    check_eq("drain", CW'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
